// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment display scanner:
// active-low segment codes (bit 6 = a ... bit 0 = g) and the scan FSM state type.
package display_pkg;

   typedef enum logic {
      ST_SHOW  = 1'b0,
      ST_GUARD = 1'b1
   } scan_state_e;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/display_scanner_seg7_decode.sv
// BCD to active-low 7-segment decoder; codes 10..15 render as blank.
module seg7_decode
   import display_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg_n
);

   // Pure lookup from digit code to segment pattern.
   always_comb begin
      seg_n = SEG_BLANK;
      case (code)
         4'd0:    seg_n = SEG_0;
         4'd1:    seg_n = SEG_1;
         4'd2:    seg_n = SEG_2;
         4'd3:    seg_n = SEG_3;
         4'd4:    seg_n = SEG_4;
         4'd5:    seg_n = SEG_5;
         4'd6:    seg_n = SEG_6;
         4'd7:    seg_n = SEG_7;
         4'd8:    seg_n = SEG_8;
         4'd9:    seg_n = SEG_9;
         default: seg_n = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed 7-segment scanner. Each digit is lit for REFRESH_DIV
// cycles followed by GUARD_CYCLES with every anode off. New data is staged
// in a pending register and promoted to the displayed register only at the
// frame boundary, so a frame never mixes old and new digits.
module display_scanner
   import display_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int REFRESH_DIV   = 50000,
   parameter int GUARD_CYCLES  = 500,
   parameter int BLANK_LEADING = 1
)
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   bcd_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  load,
   output logic [DIGITS-1:0]     anodes,
   output logic [6:0]            segments,
   output logic                  dp,
   output logic                  frame_done
);

   localparam int IDX_W   = $clog2(DIGITS);
   localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

   scan_state_e            state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   logic [4*DIGITS-1:0]    active_bcd_q, active_bcd_d;
   logic [DIGITS-1:0]      active_dp_q, active_dp_d;
   logic [4*DIGITS-1:0]    pending_bcd_q, pending_bcd_d;
   logic [DIGITS-1:0]      pending_dp_q, pending_dp_d;
   logic                   pend_valid_q, pend_valid_d;

   logic [DIGITS-1:0]      anodes_q, anodes_d;
   logic [6:0]             segments_q, segments_d;
   logic                   dp_q, dp_d;
   logic                   frame_done_q, frame_done_d;

   logic                   frame_s;
   logic [DIGITS-1:0]      blank_s;
   logic [3:0]             sel_digit_s;
   logic                   sel_blank_s;
   logic                   sel_dp_s;
   logic [6:0]             dec_seg_s;
   logic                   run_zero_s;

   // Scan sequencing: slot counter, SHOW/GUARD alternation and digit index.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      frame_s = 1'b0;
      case (state_q)
         ST_SHOW: begin
            if (cnt_q == SHOW_LAST) begin
               state_d = ST_GUARD;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + 1'b1;
            end
         end
         ST_GUARD: begin
            if (cnt_q == GUARD_LAST) begin
               state_d = ST_SHOW;
               cnt_d   = '0;
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  frame_s = 1'b1;
               end else begin
                  idx_d   = idx_q + 1'b1;
               end
            end else begin
               cnt_d   = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_SHOW;
            idx_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // Double-buffered display data; a load on the boundary cycle bypasses pending.
   always_comb begin
      active_bcd_d  = active_bcd_q;
      active_dp_d   = active_dp_q;
      pending_bcd_d = pending_bcd_q;
      pending_dp_d  = pending_dp_q;
      pend_valid_d  = pend_valid_q;
      if (frame_s) begin
         if (load) begin
            active_bcd_d = bcd_in;
            active_dp_d  = dp_in;
            pend_valid_d = 1'b0;
         end else if (pend_valid_q) begin
            active_bcd_d = pending_bcd_q;
            active_dp_d  = pending_dp_q;
            pend_valid_d = 1'b0;
         end else begin
            pend_valid_d = pend_valid_q;
         end
      end else if (load) begin
         pending_bcd_d = bcd_in;
         pending_dp_d  = dp_in;
         pend_valid_d  = 1'b1;
      end else begin
         pend_valid_d  = pend_valid_q;
      end
   end

   // Leading-zero blanking: a digit blanks when it and every higher digit are zero.
   always_comb begin
      run_zero_s = 1'b1;
      blank_s    = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         run_zero_s = run_zero_s & (active_bcd_q[i*4 +: 4] == 4'd0);
         if ((BLANK_LEADING != 0) && (i > 0)) begin
            blank_s[i] = run_zero_s;
         end else begin
            blank_s[i] = 1'b0;
         end
      end
   end

   // Select the code, blank flag and decimal point of the digit being scanned.
   always_comb begin
      sel_digit_s = 4'd0;
      sel_blank_s = 1'b0;
      sel_dp_s    = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            sel_digit_s = active_bcd_q[i*4 +: 4];
            sel_blank_s = blank_s[i];
            sel_dp_s    = active_dp_q[i];
         end else begin
            sel_digit_s = sel_digit_s;
         end
      end
   end

   seg7_decode u_decode (
      .code  (sel_digit_s),
      .seg_n (dec_seg_s)
   );

   // Next values of the registered pin drivers, derived from the current scan state.
   always_comb begin
      anodes_d     = {DIGITS{1'b1}};
      segments_d   = SEG_BLANK;
      dp_d         = 1'b1;
      frame_done_d = frame_s;
      if (state_q == ST_SHOW) begin
         for (int i = 0; i < DIGITS; i++) begin
            anodes_d[i] = (idx_q != IDX_W'(i));
         end
         segments_d = sel_blank_s ? SEG_BLANK : dec_seg_s;
         dp_d       = ~sel_dp_s;
      end else begin
         anodes_d   = {DIGITS{1'b1}};
         segments_d = SEG_BLANK;
         dp_d       = 1'b1;
      end
   end

   // All state and output registers, cleared by the synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_SHOW;
         idx_q         <= '0;
         cnt_q         <= '0;
         active_bcd_q  <= '0;
         active_dp_q   <= '0;
         pending_bcd_q <= '0;
         pending_dp_q  <= '0;
         pend_valid_q  <= 1'b0;
         anodes_q      <= {DIGITS{1'b1}};
         segments_q    <= SEG_BLANK;
         dp_q          <= 1'b1;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         active_bcd_q  <= active_bcd_d;
         active_dp_q   <= active_dp_d;
         pending_bcd_q <= pending_bcd_d;
         pending_dp_q  <= pending_dp_d;
         pend_valid_q  <= pend_valid_d;
         anodes_q      <= anodes_d;
         segments_q    <= segments_d;
         dp_q          <= dp_d;
         frame_done_q  <= frame_done_d;
      end
   end

   assign anodes     = anodes_q;
   assign segments   = segments_q;
   assign dp         = dp_q;
   assign frame_done = frame_done_q;

endmodule
